noc_test_pkt_checker: RTL
=========================

// Module: noc_test_pkt_checker
// PURPOSE
//  Flit sink/checker on the receive side of a NoC test node, fed by the node's receiver flit channel.
//  Parses head/body/tail flits and checks the destination ID, packet length and body payload pattern.
//  Keeps packet/error counters and sticky error flags for the self-test bench and status readout.
//  Exerts backpressure only through the sink_stall input.
// PARAMETERS
//  X_ID     0   this node's X coordinate, Noc_ID_X_Width bits (Noc_parameters)
//  Y_ID     0   this node's Y coordinate, Noc_ID_Y_Width bits (Noc_parameters)
//  FLIT_W   32  flit width in bits; must be >= 2+2*(XW+YW)+8 and >= 18
//  XW/YW: Noc_ID_X_Width/Noc_ID_Y_Width
// PORTS
//  noc_clk       in   1       clock; all logic on the rising edge
//  noc_rst_n     in   1       synchronous active-low reset
//  flit_valid    in   1       upstream flit valid
//  flit_ready    out  1       checker ready; equals !sink_stall (combinational)
//  flit_data     in   FLIT_W  flit
//  sink_stall    in   1       bench-driven backpressure
//  clear         in   1       synchronous clear of counters and flags
//  pkt_done      out  1       1-cycle pulse: a packet ended (tail/single accepted, or abort)
//  pkt_ok        out  1       1-cycle pulse with pkt_done if the packet had no error
//  pkt_ok_cnt    out  16      error-free packets, saturating
//  err_cnt       out  16      accepted flits that raised >=1 error, saturating
//  err_flags     out  5       sticky {ERR_HEAD,ERR_ORPHAN,ERR_DATA,ERR_LEN,ERR_DST}
//  last_src      out  XW+YW   {src_x,src_y} of the most recent accepted head
// BEHAVIOUR
//  - Flit format: [FW-1:FW-2] type: 01 head, 00 body, 10 tail, 11 single (head+tail).
//    Head/single fields from the MSB down: dst_x(XW), dst_y(YW), src_x(XW), src_y(YW); [7:0] len.
//    len = number of flits following the head, tail included. Body/tail: [15:0] = index 1..len.
//  - Accept = flit_valid & flit_ready. Nothing changes on a non-accept cycle.
//  - Reset: FSM=WAIT_HEAD; idx, len, all counters, flags, last_src and pulses = 0.
//  - FSM WAIT_HEAD:
//    - head: dst!={X_ID,Y_ID} -> ERR_DST (packet still tracked). Latch len; idx<=1.
//      len==0 -> ERR_LEN, abort. Otherwise -> IN_PKT.
//    - single: ERR_DST check as for head; len!=0 -> ERR_LEN. The packet ends.
//    - body/tail: ERR_ORPHAN; flit discarded; no pkt_done.
//  - FSM IN_PKT:
//    - body: [15:0]!=idx -> ERR_DATA. If idx==len -> ERR_LEN, abort. Else idx<=idx+1.
//    - tail: [15:0]!=idx -> ERR_DATA; idx!=len -> ERR_LEN. The packet ends -> WAIT_HEAD.
//    - head/single: ERR_HEAD; the current packet is aborted. The new flit is then processed
//      as in WAIT_HEAD in the same cycle; only one pkt_done is pulsed (for the aborted packet).
//  - Packet end or abort: pkt_done pulses in the cycle after the accept. pkt_ok and a
//    pkt_ok_cnt increment occur only if no error was flagged on any flit of that packet.
//  - err_cnt += 1 per accepted flit with any error. Both counters saturate at 16'hFFFF.
//  - err_flags are sticky OR of the per-flit error bits.
//  - clear: zeroes counters and flags in the next cycle; it wins over same-cycle increments.
//    FSM, idx and last_src are unaffected. Reset takes priority over clear.
//  - Reset mid-packet: return to WAIT_HEAD; the partial packet is dropped silently.
//  - Latency: status outputs update 1 cycle after the accepting edge.
//  - flit_ready has no dependence on flit_valid.
// TESTING  (X_ID=1, Y_ID=2, XW=YW=4, FLIT_W=32)
//  1. Head dst(1,2) src(3,0) len=3, body 1, body 2, tail 3, no stall
//     -> one pkt_done+pkt_ok; pkt_ok_cnt=1; err_cnt=0; last_src=8'h30.
//  2. Same packet with body payload 2 replaced by 5 -> err_flags=00100; err_cnt=1;
//     pkt_done with pkt_ok=0; pkt_ok_cnt=0.
//  3. Tail while in WAIT_HEAD -> ERR_ORPHAN; no pkt_done. Head len=2 followed by head len=0
//     -> ERR_HEAD and ERR_LEN; two errored flits, err_cnt=2.
//  4. Single flit with dst(0,2) -> ERR_DST; pkt_done=1; pkt_ok=0.
//     Single flit with dst(1,2) and len=0 -> pkt_ok.
//  5. Toggle sink_stall randomly during scenario 1 with flit_valid held
//     -> no flit lost or duplicated; result identical to scenario 1.
//  6. Preload err_cnt to 16'hFFFF with errors, then send one more bad flit -> err_cnt stays FFFF.
//     clear asserted together with an error -> counters read 0.
//     Reset mid-packet, then a fresh packet -> pkt_ok.

Source files
------------

// File: rtl/noc_test_pkt_checker.sv
// Receive-side flit sink for NoC self-test: checks destination, length and body index
// pattern of incoming packets, and keeps packet/error counters plus sticky error flags.
module noc_test_pkt_checker #(
  parameter int            XW     = 4,
  parameter int            YW     = 4,
  parameter logic [XW-1:0] X_ID   = '0,
  parameter logic [YW-1:0] Y_ID   = '0,
  parameter int            FLIT_W = 32
) (
  input  logic              i_noc_clk,
  input  logic              i_noc_rst_n,
  input  logic              i_flit_valid,
  output logic              o_flit_ready,
  input  logic [FLIT_W-1:0] i_flit_data,
  input  logic              i_sink_stall,
  input  logic              i_clear,
  output logic              o_pkt_done,
  output logic              o_pkt_ok,
  output logic [15:0]       o_pkt_ok_cnt,
  output logic [15:0]       o_err_cnt,
  output logic [4:0]        o_err_flags,
  output logic [XW+YW-1:0]  o_last_src
);

  localparam logic [1:0] TYPE_BODY   = 2'b00;
  localparam logic [1:0] TYPE_HEAD   = 2'b01;
  localparam logic [1:0] TYPE_TAIL   = 2'b10;
  localparam logic [1:0] TYPE_SINGLE = 2'b11;

  localparam int E_DST    = 0;
  localparam int E_LEN    = 1;
  localparam int E_DATA   = 2;
  localparam int E_ORPHAN = 3;
  localparam int E_HEAD   = 4;

  typedef enum logic {
    S_WAIT_HEAD,
    S_IN_PKT
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [7:0]       r_idx, w_idx_nxt;
  logic [7:0]       r_len, w_len_nxt;
  logic             r_pkt_err, w_pkt_err_nxt;
  logic             r_pkt_done, r_pkt_ok;
  logic [15:0]      r_pkt_ok_cnt, r_err_cnt;
  logic [4:0]       r_err_flags;
  logic [XW+YW-1:0] r_last_src;

  logic             w_ready, w_accept, w_is_head, w_dst_bad;
  logic [1:0]       w_type;
  logic [XW+YW-1:0] w_dst, w_src;
  logic [7:0]       w_flit_len;
  logic [15:0]      w_payload;
  logic [4:0]       w_err;
  logic             w_end, w_end_ok;

  assign w_ready    = !i_sink_stall;
  assign w_accept   = i_flit_valid & w_ready;
  assign w_type     = i_flit_data[FLIT_W-1 -: 2];
  assign w_dst      = i_flit_data[FLIT_W-3 -: XW+YW];
  assign w_src      = i_flit_data[FLIT_W-3-XW-YW -: XW+YW];
  assign w_flit_len = i_flit_data[7:0];
  assign w_payload  = i_flit_data[15:0];
  assign w_is_head  = (w_type == TYPE_HEAD) || (w_type == TYPE_SINGLE);
  assign w_dst_bad  = (w_dst != {X_ID, Y_ID});

  always_ff @(posedge i_noc_clk) begin
    if (!i_noc_rst_n) begin
      r_state      <= S_WAIT_HEAD;
      r_idx        <= '0;
      r_len        <= '0;
      r_pkt_err    <= 1'b0;
      r_pkt_done   <= 1'b0;
      r_pkt_ok     <= 1'b0;
      r_pkt_ok_cnt <= '0;
      r_err_cnt    <= '0;
      r_err_flags  <= '0;
      r_last_src   <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_idx      <= w_idx_nxt;
      r_len      <= w_len_nxt;
      r_pkt_err  <= w_pkt_err_nxt;
      r_pkt_done <= w_end;
      r_pkt_ok   <= w_end_ok;
      if (w_accept && w_is_head) begin
        r_last_src <= w_src;
      end
      // Clear beats any increment or flag update landing in the same cycle.
      if (i_clear) begin
        r_pkt_ok_cnt <= '0;
        r_err_cnt    <= '0;
        r_err_flags  <= '0;
      end else begin
        if (w_end_ok && (r_pkt_ok_cnt != 16'hFFFF)) begin
          r_pkt_ok_cnt <= r_pkt_ok_cnt + 16'd1;
        end
        if ((|w_err) && (r_err_cnt != 16'hFFFF)) begin
          r_err_cnt <= r_err_cnt + 16'd1;
        end
        r_err_flags <= r_err_flags | w_err;
      end
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_idx_nxt     = r_idx;
    w_len_nxt     = r_len;
    w_pkt_err_nxt = r_pkt_err;
    w_err         = '0;
    w_end         = 1'b0;
    w_end_ok      = 1'b0;
    if (w_accept) begin
      // A head inside a packet aborts it; the head itself is then parsed as a fresh start.
      if ((r_state == S_IN_PKT) && w_is_head) begin
        w_err[E_HEAD] = 1'b1;
        w_end         = 1'b1;
        w_state_nxt   = S_WAIT_HEAD;
      end
      if ((r_state == S_WAIT_HEAD) || w_is_head) begin
        case (w_type)
          TYPE_HEAD: begin
            w_err[E_DST] = w_dst_bad;
            w_len_nxt    = w_flit_len;
            w_idx_nxt    = 8'd1;
            if (w_flit_len == 8'd0) begin
              w_err[E_LEN] = 1'b1;
              w_end        = 1'b1;
              w_state_nxt  = S_WAIT_HEAD;
            end else begin
              w_state_nxt   = S_IN_PKT;
              w_pkt_err_nxt = w_dst_bad | w_err[E_HEAD];
            end
          end
          TYPE_SINGLE: begin
            w_err[E_DST] = w_dst_bad;
            w_err[E_LEN] = (w_flit_len != 8'd0);
            w_state_nxt  = S_WAIT_HEAD;
            if (r_state == S_WAIT_HEAD) begin
              w_end    = 1'b1;
              w_end_ok = !w_dst_bad && (w_flit_len == 8'd0);
            end
          end
          default: begin
            w_err[E_ORPHAN] = 1'b1;
          end
        endcase
      end else begin
        w_err[E_DATA] = (w_payload != {8'h00, r_idx});
        if (w_type == TYPE_BODY) begin
          if (r_idx == r_len) begin
            w_err[E_LEN] = 1'b1;
            w_end        = 1'b1;
            w_state_nxt  = S_WAIT_HEAD;
          end else begin
            w_idx_nxt     = r_idx + 8'd1;
            w_pkt_err_nxt = r_pkt_err | w_err[E_DATA];
          end
        end else begin
          w_err[E_LEN] = (r_idx != r_len);
          w_end        = 1'b1;
          w_end_ok     = !(r_pkt_err | w_err[E_DATA] | w_err[E_LEN]);
          w_state_nxt  = S_WAIT_HEAD;
        end
      end
    end
  end

  assign o_flit_ready = w_ready;
  assign o_pkt_done   = r_pkt_done;
  assign o_pkt_ok     = r_pkt_ok;
  assign o_pkt_ok_cnt = r_pkt_ok_cnt;
  assign o_err_cnt    = r_err_cnt;
  assign o_err_flags  = r_err_flags;
  assign o_last_src   = r_last_src;

endmodule
